pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: operand forwarding, load-use bubbles,
// branch flushes and a beat-sequencing data-memory FSM with per-beat timeout.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int VEC_BEATS      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] de_rs1,
  input  logic [4:0] de_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_pc_src,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_reg_write,
  input  logic       wb_reg_write,
  input  logic       mem_op_valid,
  input  logic       mem_vector_op,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic [1:0] dmem_beat,
  output logic       fe_stall,
  output logic       de_stall,
  output logic       de_clear,
  output logic       ex_clear,
  output logic       stall_all,
  output logic [1:0] fw_op1,
  output logic [1:0] fw_op2,
  output logic       mem_err
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] VEC_LAST  = 2'(VEC_BEATS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_reg, state_next;
  logic [1:0] beat_reg, beat_next;
  logic [1:0] last_beat_reg, last_beat_next;
  logic [7:0] wait_reg, wait_next;
  logic       mem_err_reg, mem_err_next;
  logic       last_ack, timeout;

  // Forwarding: mem stage is younger than wb, so it wins when both match.
  logic [1:0][4:0] ex_rs;
  logic [1:0][1:0] fw_sel;
  assign ex_rs = {ex_rs2, ex_rs1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic mem_hit, wb_hit;
    assign mem_hit    = mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs[gi]);
    assign wb_hit     = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs[gi]);
    assign fw_sel[gi] = mem_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
  end

  assign fw_op1 = fw_sel[0];
  assign fw_op2 = fw_sel[1];

  logic load_use;
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == de_rs1) || (ex_rd == de_rs2));

  always_comb begin
    state_next     = state_reg;
    beat_next      = beat_reg;
    last_beat_next = last_beat_reg;
    wait_next      = wait_reg;
    mem_err_next   = mem_err_reg;
    last_ack       = 1'b0;
    timeout        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_op_valid) begin
          state_next     = BUSY;
          beat_next      = 2'd0;
          wait_next      = 8'd0;
          last_beat_next = mem_vector_op ? VEC_LAST : 2'd0;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          wait_next = 8'd0;
          if (beat_reg == last_beat_reg) begin
            last_ack   = 1'b1;
            state_next = IDLE;
            beat_next  = 2'd0;
          end else begin
            beat_next = beat_reg + 2'd1;
          end
        end else if (wait_reg == WAIT_LAST) begin
          // The increment would reach the limit: abandon the access.
          timeout      = 1'b1;
          state_next   = IDLE;
          beat_next    = 2'd0;
          wait_next    = 8'd0;
          mem_err_next = 1'b1;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      beat_reg      <= 2'd0;
      last_beat_reg <= 2'd0;
      wait_reg      <= 8'd0;
      mem_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      last_beat_reg <= last_beat_next;
      wait_reg      <= wait_next;
      mem_err_reg   <= mem_err_next;
    end
  end

  // Gated by rst_n so a pending op cannot freeze the pipe while held in reset.
  assign stall_all = rst_n &&
                     (((state_reg == IDLE) && mem_op_valid) ||
                      ((state_reg == BUSY) && !last_ack && !timeout));

  assign dmem_req  = (state_reg == BUSY);
  assign dmem_beat = beat_reg;
  assign mem_err   = mem_err_reg;

  // A freeze suppresses bubbles and flushes; a taken branch suppresses load-use stalls.
  assign fe_stall = !stall_all && load_use && !ex_pc_src;
  assign de_stall = !stall_all && load_use && !ex_pc_src;
  assign de_clear = !stall_all && ex_pc_src;
  assign ex_clear = !stall_all && (ex_pc_src || load_use);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a cycle-level
// behavioural model of the memory access and the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int TMO  = 4;
  localparam int VECB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_mem_read, ex_pc_src, mem_reg_write, wb_reg_write;
  logic       mem_op_valid, mem_vector_op, dmem_ack;
  logic       dmem_req, fe_stall, de_stall, de_clear, ex_clear, stall_all, mem_err;
  logic [1:0] dmem_beat, fw_op1, fw_op2;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the access in flight
  bit m_busy;
  int m_beat, m_total, m_wait;
  bit m_err;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TMO), .VEC_BEATS(VECB)) dut (
    .clk(clk), .rst_n(rst_n),
    .de_rs1(de_rs1), .de_rs2(de_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_pc_src(ex_pc_src),
    .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_op_valid(mem_op_valid), .mem_vector_op(mem_vector_op), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_beat(dmem_beat),
    .fe_stall(fe_stall), .de_stall(de_stall), .de_clear(de_clear), .ex_clear(ex_clear),
    .stall_all(stall_all), .fw_op1(fw_op1), .fw_op2(fw_op2), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fw_model(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Compare every output with the model for the current inputs.
  task automatic check_all();
    bit lu, done, stall;
    if (!rst_n) begin
      m_busy = 0; m_beat = 0; m_wait = 0; m_err = 0;
    end
    lu    = ex_mem_read && ex_rd != 0 && (ex_rd == de_rs1 || ex_rd == de_rs2);
    done  = m_busy && ((dmem_ack && m_beat == m_total - 1) || (!dmem_ack && m_wait + 1 == TMO));
    stall = rst_n && ((!m_busy && mem_op_valid) || (m_busy && !done));
    chk("fw_op1", 8'(fw_op1), 8'(fw_model(ex_rs1)));
    chk("fw_op2", 8'(fw_op2), 8'(fw_model(ex_rs2)));
    chk("stall_all", 8'(stall_all), 8'(stall));
    chk("fe_stall", 8'(fe_stall), 8'(!stall && lu && !ex_pc_src));
    chk("de_stall", 8'(de_stall), 8'(!stall && lu && !ex_pc_src));
    chk("de_clear", 8'(de_clear), 8'(!stall && ex_pc_src));
    chk("ex_clear", 8'(ex_clear), 8'(!stall && (ex_pc_src || lu)));
    chk("dmem_req", 8'(dmem_req), 8'(m_busy));
    chk("mem_err", 8'(mem_err), 8'(m_err));
    if (m_busy) chk("dmem_beat", 8'(dmem_beat), 8'(m_beat));
  endtask

  task automatic advance_model();
    if (!rst_n) return;
    if (!m_busy) begin
      if (mem_op_valid) begin
        m_busy = 1; m_beat = 0; m_wait = 0;
        m_total = mem_vector_op ? VECB : 1;
      end
    end else if (dmem_ack) begin
      m_wait = 0;
      if (m_beat == m_total - 1) m_busy = 0;
      else m_beat++;
    end else if (m_wait + 1 == TMO) begin
      m_busy = 0; m_wait = 0; m_err = 1;
    end else begin
      m_wait++;
    end
  endtask

  task automatic step_begin();
    #2;
    check_all();
  endtask

  task automatic step_end();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    step_begin();
    step_end();
  endtask

  task automatic clear_inputs();
    {de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {ex_mem_read, ex_pc_src, mem_reg_write, wb_reg_write} = '0;
    {mem_op_valid, mem_vector_op, dmem_ack} = '0;
  endtask

  task automatic rand_inputs();
    de_rs1 = 5'($urandom_range(0, 3)); de_rs2 = 5'($urandom_range(0, 3));
    ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
    ex_rd  = 5'($urandom_range(0, 3));
    mem_rd = 5'($urandom_range(0, 3)); wb_rd  = 5'($urandom_range(0, 3));
    ex_mem_read   = 1'($urandom_range(0, 1));
    ex_pc_src     = ($urandom_range(0, 3) == 0);
    mem_reg_write = 1'($urandom_range(0, 1));
    wb_reg_write  = 1'($urandom_range(0, 1));
    mem_op_valid  = ($urandom_range(0, 2) == 0);
    mem_vector_op = 1'($urandom_range(0, 1));
    dmem_ack      = 1'($urandom_range(0, 1));
  endtask

  initial begin
    m_busy = 0; m_beat = 0; m_total = 1; m_wait = 0; m_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    mem_op_valid = 1'b1;
    step_begin();
    chk("rst_stall", 8'(stall_all), 8'd0);
    chk("rst_req", 8'(dmem_req), 8'd0);
    chk("rst_beat", 8'(dmem_beat), 8'd0);
    chk("rst_err", 8'(mem_err), 8'd0);
    step_end();
    mem_op_valid = 1'b0;
    cycle();
    rst_n = 1'b1;

    // Forwarding priority and x0 exclusion
    mem_rd = 5'd3; wb_rd = 5'd3; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 5'd3;
    step_begin(); chk("fw_mem", 8'(fw_op1), 8'h2); step_end();
    mem_reg_write = 0;
    step_begin(); chk("fw_wb", 8'(fw_op1), 8'h1); step_end();
    wb_rd = 5'd0;
    step_begin(); chk("fw_none", 8'(fw_op1), 8'h0); step_end();
    clear_inputs();

    // Load-use bubble, then branch override
    ex_mem_read = 1; ex_rd = 5'd5; de_rs2 = 5'd5;
    step_begin();
    chk("lu_fe", 8'(fe_stall), 8'd1); chk("lu_de", 8'(de_stall), 8'd1);
    chk("lu_exclr", 8'(ex_clear), 8'd1);
    step_end();
    ex_pc_src = 1;
    step_begin();
    chk("br_declr", 8'(de_clear), 8'd1); chk("br_exclr", 8'(ex_clear), 8'd1);
    chk("br_fe", 8'(fe_stall), 8'd0);
    step_end();

    // Scalar op acked on first busy cycle; freeze masks the pending branch
    mem_op_valid = 1;
    step_begin(); chk("sc_stall0", 8'(stall_all), 8'd1); chk("frz_declr", 8'(de_clear), 8'd0); step_end();
    dmem_ack = 1;
    step_begin(); chk("sc_req", 8'(dmem_req), 8'd1); chk("sc_beat", 8'(dmem_beat), 8'd0); step_end();
    clear_inputs();
    step_begin(); chk("sc_req_off", 8'(dmem_req), 8'd0); step_end();

    // Vector op with a gap cycle before every ack
    mem_op_valid = 1; mem_vector_op = 1;
    cycle();
    for (int i = 0; i < VECB; i++) begin
      dmem_ack = 0;
      cycle();
      dmem_ack = 1;
      step_begin();
      chk("vec_beat", 8'(dmem_beat), 8'(i));
      chk("vec_stall", 8'(stall_all), 8'(i != VECB - 1));
      step_end();
    end
    clear_inputs();
    cycle();

    // Timeout with no ack; error flag is sticky
    mem_op_valid = 1;
    cycle();
    for (int i = 1; i <= TMO; i++) begin
      step_begin();
      chk("tmo_req", 8'(dmem_req), 8'd1);
      chk("tmo_stall", 8'(stall_all), 8'(i != TMO));
      step_end();
    end
    mem_op_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step_begin(); chk("tmo_err", 8'(mem_err), 8'd1); chk("tmo_idle", 8'(dmem_req), 8'd0); step_end();
    end

    // Reset in the middle of beat 2 of a vector op
    mem_op_valid = 1; mem_vector_op = 1;
    cycle();
    dmem_ack = 1;
    cycle(); cycle();
    dmem_ack = 0;
    step_begin(); chk("pre_rst_beat", 8'(dmem_beat), 8'd2); step_end();
    rst_n = 1'b0;
    #1;
    chk("arst_req", 8'(dmem_req), 8'd0);
    chk("arst_stall", 8'(stall_all), 8'd0);
    chk("arst_beat", 8'(dmem_beat), 8'd0);
    chk("arst_err", 8'(mem_err), 8'd0);
    ex_rs2 = 5'd7; mem_rd = 5'd7; mem_reg_write = 1; ex_pc_src = 1;
    cycle();
    rst_n = 1'b1;
    clear_inputs();
    cycle();

    // Randomized traffic including back-to-back accesses
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
